// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU execution sequencer.
// States, condition codes and flag bit positions.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_COMMIT,
      S_RESP
   } state_e;

   localparam logic [3:0] CC_AL = 4'd0;
   localparam logic [3:0] CC_EQ = 4'd1;
   localparam logic [3:0] CC_NE = 4'd2;
   localparam logic [3:0] CC_CS = 4'd3;
   localparam logic [3:0] CC_CC = 4'd4;
   localparam logic [3:0] CC_MI = 4'd5;
   localparam logic [3:0] CC_PL = 4'd6;
   localparam logic [3:0] CC_VS = 4'd7;
   localparam logic [3:0] CC_VC = 4'd8;
   localparam logic [3:0] CC_HI = 4'd9;
   localparam logic [3:0] CC_LS = 4'd10;
   localparam logic [3:0] CC_GE = 4'd11;
   localparam logic [3:0] CC_LT = 4'd12;
   localparam logic [3:0] CC_GT = 4'd13;
   localparam logic [3:0] CC_LE = 4'd14;
   localparam logic [3:0] CC_NV = 4'd15;

   localparam int FLAG_C  = 0;
   localparam int FLAG_N  = 1;
   localparam int FLAG_Z  = 2;
   localparam int FLAG_OV = 3;

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator: decides whether an op executes
// given the current flag register contents.
module cond_eval
   import alu_ctrl_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       pass
);

   logic c, n, z, v;

   always_comb begin
      c    = flags[FLAG_C];
      n    = flags[FLAG_N];
      z    = flags[FLAG_Z];
      v    = flags[FLAG_OV];
      pass = 1'b0;
      unique case (cond)
         CC_AL: pass = 1'b1;
         CC_EQ: pass = z;
         CC_NE: pass = !z;
         CC_CS: pass = c;
         CC_CC: pass = !c;
         CC_MI: pass = n;
         CC_PL: pass = !n;
         CC_VS: pass = v;
         CC_VC: pass = !v;
         CC_HI: pass = c && !z;
         CC_LS: pass = !c || z;
         CC_GE: pass = (n == v);
         CC_LT: pass = (n != v);
         CC_GT: pass = !z && (n == v);
         CC_LE: pass = z || (n != v);
         CC_NV: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Two-requester sequencer for a shared ALU and flag register.
// One transaction in flight: arbitrate, check cond, execute, commit, respond.
module alu_exec_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int OPW     = 4,
   parameter int ALU_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*OPW-1:0]   req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   input  logic [7:0]         req_cond,
   input  logic [1:0]         req_setf,
   output logic [OPW-1:0]     alu_op,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic [3:0]         flags_in,
   output logic               flag_execute,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [WIDTH-1:0]   rsp_result,
   output logic               rsp_skipped
);

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             last_q, last_d;
   logic             id_q, id_d;
   logic             setf_q, setf_d;
   logic [OPW-1:0]   alu_op_q, alu_op_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             skip_q, skip_d;

   logic             win;
   logic [OPW-1:0]   sel_op;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [3:0]       sel_cond;
   logic             sel_setf;
   logic             cond_pass;

   // On a tie the requester that did not win last time is served
   always_comb begin
      if (req_valid == 2'b11) win = ~last_q;
      else                    win = req_valid[1];
      sel_op   = win ? req_op[OPW +: OPW]     : req_op[0 +: OPW];
      sel_a    = win ? req_a[WIDTH +: WIDTH]  : req_a[0 +: WIDTH];
      sel_b    = win ? req_b[WIDTH +: WIDTH]  : req_b[0 +: WIDTH];
      sel_cond = win ? req_cond[7:4]          : req_cond[3:0];
      sel_setf = win ? req_setf[1]            : req_setf[0];
   end

   cond_eval u_cond (
      .flags (flags_in),
      .cond  (sel_cond),
      .pass  (cond_pass)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      id_d         = id_q;
      setf_d       = setf_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      res_d        = res_q;
      skip_d       = skip_q;
      req_ready    = 2'b00;
      flag_execute = 1'b0;
      rsp_valid    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rst_n && (req_valid != 2'b00)) begin
               req_ready = win ? 2'b10 : 2'b01;
               last_d    = win;
               id_d      = win;
               setf_d    = sel_setf;
               if (cond_pass) begin
                  alu_op_d = sel_op;
                  alu_a_d  = sel_a;
                  alu_b_d  = sel_b;
                  cnt_d    = 3'(ALU_LAT);
                  state_d  = S_EXEC;
               end else begin
                  res_d   = '0;
                  skip_d  = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q == 3'd0) state_d = S_COMMIT;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_COMMIT: begin
            res_d        = alu_result;
            skip_d       = 1'b0;
            flag_execute = setf_q;
            state_d      = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 3'd0;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         setf_q   <= 1'b0;
         alu_op_q <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         res_q    <= '0;
         skip_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         id_q     <= id_d;
         setf_q   <= setf_d;
         alu_op_q <= alu_op_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         res_q    <= res_d;
         skip_q   <= skip_d;
      end
   end

   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign rsp_id      = id_q;
   assign rsp_result  = res_q;
   assign rsp_skipped = skip_q;

endmodule
